// File: rtl/snake_fpga_pkg.sv
// Shared constants for the snake rendering engine: command encoding,
// screen geometry, FSM states and bus address offset helpers.
package snake_fpga_pkg;

  localparam int MSG_CMD_OFFSET = 28;
  localparam int MSG_CH_OFFSET  = 20;
  localparam int MSG_X_OFFSET   = 8;
  localparam int MSG_Y_OFFSET   = 0;

  localparam int CMD_W = 4;
  localparam int CH_W  = 8;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;

  localparam logic [CMD_W-1:0] CMD_NOP       = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SNAKE_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SNAKE_DEL = 4'd2;
  localparam logic [CMD_W-1:0] CMD_FOOD_ADD  = 4'd3;
  localparam logic [CMD_W-1:0] CMD_CLEAR     = 4'd4;
  localparam logic [CMD_W-1:0] CMD_CHAR      = 4'd5;

  localparam logic [X_W-1:0] SCREEN_W = 9'd320;
  localparam logic [Y_W-1:0] SCREEN_H = 8'd240;
  localparam logic [X_W-1:0] CHAR_W   = 9'd80;
  localparam logic [Y_W-1:0] CHAR_H   = 8'd60;
  localparam logic [X_W-1:0] X_MAX    = 9'd319;
  localparam logic [Y_W-1:0] Y_MAX    = 8'd239;

  localparam logic [3:0] REG_CMD  = 4'd0;
  localparam logic [3:0] REG_CTRL = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_PX_WR,
    ST_CH_WR,
    ST_CLR_WR
  } state_e;

  // Pixel rows are 1024 bytes apart, pixels are 2 bytes wide.
  function automatic logic [31:0] px_offset(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ({24'd0, y} << 10) + ({23'd0, x} << 1);
  endfunction

  function automatic logic [31:0] ch_offset(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ({24'd0, y} << 7) + {23'd0, x};
  endfunction

endpackage

// File: rtl/snake_fpga_writer.sv
// Single-beat Avalon-MM write master: a start pulse loads address/data and
// raises the strobe, which stays up until the slave drops waitrequest.
module snake_avalon_writer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        waitrequest_i,
  output logic [31:0] address_o,
  output logic        write_o,
  output logic [15:0] writedata_o,
  output logic        done_o
);

  logic        write_q;
  logic [31:0] addr_q;
  logic [15:0] data_q;

  assign done_o      = write_q & ~waitrequest_i;
  assign write_o     = write_q;
  assign address_o   = addr_q;
  assign writedata_o = data_q;

  // A start in the same cycle as done chains the next beat without a gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (start_i) begin
      write_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (done_o) begin
      write_q <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_fpga.sv
// Snake rendering engine: takes draw commands from the HPS slave port and
// turns them into pixel/char buffer writes through two Avalon write masters.
module snake_fpga
  import snake_fpga_pkg::*;
#(
  parameter logic [31:0] PX_BASE     = 32'h0800_0000,
  parameter logic [31:0] CH_BASE     = 32'h0900_0000,
  parameter logic [15:0] SNAKE_COLOR = 16'h07E0,
  parameter logic [15:0] FOOD_COLOR  = 16'hF800,
  parameter logic [15:0] BG_COLOR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] vga_ch_address,
  output logic        vga_ch_read,
  input  logic        vga_ch_waitrequest,
  input  logic [15:0] vga_ch_readdata,
  output logic        vga_ch_write,
  output logic [15:0] vga_ch_writedata,
  output logic [31:0] vga_px_address,
  output logic        vga_px_read,
  input  logic        vga_px_waitrequest,
  input  logic [15:0] vga_px_readdata,
  output logic        vga_px_write,
  output logic [15:0] vga_px_writedata,
  input  logic [3:0]  hps_address,
  input  logic        hps_read,
  output logic [31:0] hps_readdata,
  input  logic        hps_write,
  input  logic [31:0] hps_writedata,
  output logic        hps_waitrequest
);

  state_e          state_q;
  logic [31:0]     cmd_q;
  logic [31:0]     cmd_count_q;
  logic            err_q;
  logic [X_W-1:0]  clr_x_q;
  logic [Y_W-1:0]  clr_y_q;

  logic [CMD_W-1:0] cmd_code;
  logic [CH_W-1:0]  cmd_ch;
  logic [X_W-1:0]   cmd_x;
  logic [Y_W-1:0]   cmd_y;
  logic             busy, cmd_accept, status_clear;
  logic             px_cmd, px_in_range, ch_in_range, clr_last;
  logic [X_W-1:0]   clr_nx;
  logic [Y_W-1:0]   clr_ny;
  logic [15:0]      px_color;
  logic             px_start, ch_start, px_done, ch_done;
  logic [31:0]      px_addr, ch_addr;
  logic [15:0]      px_data, ch_data;
  logic             unused_bits;

  assign cmd_code = cmd_q[MSG_CMD_OFFSET +: CMD_W];
  assign cmd_ch   = cmd_q[MSG_CH_OFFSET  +: CH_W];
  assign cmd_x    = cmd_q[MSG_X_OFFSET   +: X_W];
  assign cmd_y    = cmd_q[MSG_Y_OFFSET   +: Y_W];

  assign busy         = (state_q != ST_IDLE);
  assign cmd_accept   = hps_write && (hps_address == REG_CMD) && !busy;
  assign status_clear = hps_write && (hps_address == REG_CTRL) && hps_writedata[0];
  // Only command writes stall; the stall lifts in the cycle the engine is idle.
  assign hps_waitrequest = hps_write && (hps_address == REG_CMD) && busy;

  assign px_cmd      = cmd_code inside {CMD_SNAKE_ADD, CMD_SNAKE_DEL, CMD_FOOD_ADD};
  assign px_in_range = (cmd_x < SCREEN_W) && (cmd_y < SCREEN_H);
  assign ch_in_range = (cmd_x < CHAR_W) && (cmd_y < CHAR_H);
  assign clr_last    = (clr_x_q == X_MAX) && (clr_y_q == Y_MAX);

  assign vga_ch_read = 1'b0;
  assign vga_px_read = 1'b0;
  assign unused_bits = ^{vga_ch_readdata, vga_px_readdata, cmd_q[19:17]};

  always_comb begin
    clr_nx = clr_x_q + 9'd1;
    clr_ny = clr_y_q;
    if (clr_x_q == X_MAX) begin
      clr_nx = '0;
      clr_ny = clr_y_q + 8'd1;
    end
  end

  always_comb begin
    case (cmd_code)
      CMD_SNAKE_ADD: px_color = SNAKE_COLOR;
      CMD_FOOD_ADD:  px_color = FOOD_COLOR;
      default:       px_color = BG_COLOR;
    endcase
  end

  always_comb begin
    px_start = 1'b0;
    px_addr  = PX_BASE + px_offset(cmd_x, cmd_y);
    px_data  = px_color;
    ch_start = 1'b0;
    ch_addr  = CH_BASE + ch_offset(cmd_x, cmd_y);
    ch_data  = {8'd0, cmd_ch};
    case (state_q)
      ST_DECODE: begin
        if (px_cmd && px_in_range) px_start = 1'b1;
        if (cmd_code == CMD_CLEAR) begin
          px_start = 1'b1;
          px_addr  = PX_BASE;
          px_data  = BG_COLOR;
        end
        if (cmd_code == CMD_CHAR && ch_in_range) ch_start = 1'b1;
      end
      ST_CLR_WR: begin
        px_data = BG_COLOR;
        if (px_done && !clr_last) begin
          px_start = 1'b1;
          px_addr  = PX_BASE + px_offset(clr_nx, clr_ny);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hps_readdata = '0;
    if (hps_read) begin
      case (hps_address)
        REG_CMD:  hps_readdata = {30'd0, err_q, busy};
        REG_CTRL: hps_readdata = cmd_count_q;
        default:  hps_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cmd_count_q <= '0;
      err_q       <= 1'b0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            cmd_q   <= hps_writedata;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= ST_IDLE;
          if (px_cmd) begin
            if (px_in_range) state_q <= ST_PX_WR;
            else             err_q   <= 1'b1;
          end else if (cmd_code == CMD_CLEAR) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
            state_q <= ST_CLR_WR;
          end else if (cmd_code == CMD_CHAR) begin
            if (ch_in_range) state_q <= ST_CH_WR;
            else             err_q   <= 1'b1;
          end
        end
        ST_PX_WR: begin
          if (px_done) begin
            cmd_count_q <= cmd_count_q + 32'd1;
            state_q     <= ST_IDLE;
          end
        end
        ST_CH_WR: begin
          if (ch_done) begin
            cmd_count_q <= cmd_count_q + 32'd1;
            state_q     <= ST_IDLE;
          end
        end
        ST_CLR_WR: begin
          if (px_done) begin
            if (clr_last) begin
              cmd_count_q <= cmd_count_q + 32'd1;
              state_q     <= ST_IDLE;
            end else begin
              clr_x_q <= clr_nx;
              clr_y_q <= clr_ny;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A software clear wins over a same-cycle completion or error.
      if (status_clear) begin
        err_q       <= 1'b0;
        cmd_count_q <= '0;
      end
    end
  end

  snake_avalon_writer u_px_writer (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (px_start),
    .addr_i        (px_addr),
    .data_i        (px_data),
    .waitrequest_i (vga_px_waitrequest),
    .address_o     (vga_px_address),
    .write_o       (vga_px_write),
    .writedata_o   (vga_px_writedata),
    .done_o        (px_done)
  );

  snake_avalon_writer u_ch_writer (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (ch_start),
    .addr_i        (ch_addr),
    .data_i        (ch_data),
    .waitrequest_i (vga_ch_waitrequest),
    .address_o     (vga_ch_address),
    .write_o       (vga_ch_write),
    .writedata_o   (vga_ch_writedata),
    .done_o        (ch_done)
  );

endmodule

// File: tb/tb_snake_fpga.sv
// Directed bench for snake_fpga: a command-level model predicts every bus
// write and the status registers; a negedge monitor checks the buses.
module tb_snake_fpga;

  localparam logic [31:0] PX_BASE = 32'h0800_0000;
  localparam logic [31:0] CH_BASE = 32'h0900_0000;
  localparam logic [15:0] SNAKE_C = 16'h07E0;
  localparam logic [15:0] FOOD_C  = 16'hF800;
  localparam logic [15:0] BG_C    = 16'h0000;

  logic        clk, reset_n;
  logic [31:0] vga_ch_address, vga_px_address;
  logic        vga_ch_read, vga_ch_waitrequest, vga_ch_write;
  logic [15:0] vga_ch_readdata, vga_ch_writedata;
  logic        vga_px_read, vga_px_waitrequest, vga_px_write;
  logic [15:0] vga_px_readdata, vga_px_writedata;
  logic [3:0]  hps_address;
  logic        hps_read, hps_write, hps_waitrequest;
  logic [31:0] hps_readdata, hps_writedata;

  snake_fpga dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .vga_ch_address     (vga_ch_address),
    .vga_ch_read        (vga_ch_read),
    .vga_ch_waitrequest (vga_ch_waitrequest),
    .vga_ch_readdata    (vga_ch_readdata),
    .vga_ch_write       (vga_ch_write),
    .vga_ch_writedata   (vga_ch_writedata),
    .vga_px_address     (vga_px_address),
    .vga_px_read        (vga_px_read),
    .vga_px_waitrequest (vga_px_waitrequest),
    .vga_px_readdata    (vga_px_readdata),
    .vga_px_write       (vga_px_write),
    .vga_px_writedata   (vga_px_writedata),
    .hps_address        (hps_address),
    .hps_read           (hps_read),
    .hps_readdata       (hps_readdata),
    .hps_write          (hps_write),
    .hps_writedata      (hps_writedata),
    .hps_waitrequest    (hps_waitrequest)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [47:0] px_exp_q[$];
  logic [47:0] ch_exp_q[$];
  logic [31:0] exp_count = '0;
  logic        exp_err = 1'b0;
  int          px_wr_count = 0, ch_wr_count = 0, px_stall_cnt = 0;
  logic [31:0] last_px_addr = '0, last_ch_addr = '0;
  logic [15:0] last_px_data = '0, last_ch_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-level model: what each accepted command must put on the buses.
  task automatic model_cmd(input logic [31:0] w);
    int code, x, y;
    logic [15:0] col;
    code = int'(w[31:28]);
    x    = int'(w[16:8]);
    y    = int'(w[7:0]);
    case (code)
      1, 2, 3: begin
        col = (code == 1) ? SNAKE_C : (code == 3) ? FOOD_C : BG_C;
        if (x < 320 && y < 240) begin
          px_exp_q.push_back({PX_BASE + 32'(y * 1024 + x * 2), col});
          exp_count = exp_count + 32'd1;
        end else exp_err = 1'b1;
      end
      4: begin
        for (int yy = 0; yy < 240; yy++)
          for (int xx = 0; xx < 320; xx++)
            px_exp_q.push_back({PX_BASE + 32'(yy * 1024 + xx * 2), BG_C});
        exp_count = exp_count + 32'd1;
      end
      5: begin
        if (x < 80 && y < 60) begin
          ch_exp_q.push_back({CH_BASE + 32'(y * 128 + x), 8'h00, w[27:20]});
          exp_count = exp_count + 32'd1;
        end else exp_err = 1'b1;
      end
      default: ;
    endcase
  endtask

  // ---------------- bus monitor / compare ----------------
  logic        px_stall_prev = 1'b0, ch_stall_prev = 1'b0;
  logic [47:0] px_hold, ch_hold, px_exp_w, ch_exp_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      px_stall_prev = 1'b0;
      ch_stall_prev = 1'b0;
    end else begin
      checks++;
      if ({vga_px_read, vga_ch_read} !== 2'b00) begin
        errors++;
        $display("FAIL read_strobe: got %b expected 00", {vga_px_read, vga_ch_read});
      end
      if (px_stall_prev) begin
        checks++;
        if (!vga_px_write || {vga_px_address, vga_px_writedata} !== px_hold) begin
          errors++;
          $display("FAIL px_hold: got wr=%b %h expected wr=1 %h", vga_px_write,
                   {vga_px_address, vga_px_writedata}, px_hold);
        end
      end
      if (vga_px_write && !vga_px_waitrequest) begin
        checks++;
        if (px_exp_q.size() == 0) begin
          errors++;
          $display("FAIL px_unexpected: got %h %h expected no write", vga_px_address, vga_px_writedata);
        end else begin
          px_exp_w = px_exp_q.pop_front();
          if ({vga_px_address, vga_px_writedata} !== px_exp_w) begin
            errors++;
            $display("FAIL px_write: got %h expected %h", {vga_px_address, vga_px_writedata}, px_exp_w);
          end
        end
        px_wr_count++;
        last_px_addr = vga_px_address;
        last_px_data = vga_px_writedata;
      end
      if (vga_px_write && vga_px_waitrequest) px_stall_cnt++;
      px_stall_prev = vga_px_write && vga_px_waitrequest;
      px_hold = {vga_px_address, vga_px_writedata};

      if (ch_stall_prev) begin
        checks++;
        if (!vga_ch_write || {vga_ch_address, vga_ch_writedata} !== ch_hold) begin
          errors++;
          $display("FAIL ch_hold: got wr=%b %h expected wr=1 %h", vga_ch_write,
                   {vga_ch_address, vga_ch_writedata}, ch_hold);
        end
      end
      if (vga_ch_write && !vga_ch_waitrequest) begin
        checks++;
        if (ch_exp_q.size() == 0) begin
          errors++;
          $display("FAIL ch_unexpected: got %h %h expected no write", vga_ch_address, vga_ch_writedata);
        end else begin
          ch_exp_w = ch_exp_q.pop_front();
          if ({vga_ch_address, vga_ch_writedata} !== ch_exp_w) begin
            errors++;
            $display("FAIL ch_write: got %h expected %h", {vga_ch_address, vga_ch_writedata}, ch_exp_w);
          end
        end
        ch_wr_count++;
        last_ch_addr = vga_ch_address;
        last_ch_data = vga_ch_writedata;
      end
      ch_stall_prev = vga_ch_write && vga_ch_waitrequest;
      ch_hold = {vga_ch_address, vga_ch_writedata};
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk(input logic [3:0] code, input logic [7:0] ch,
                                     input logic [8:0] x, input logic [7:0] y);
    return {code, ch, 3'b000, x, y};
  endfunction

  // Hold a command write for ncyc cycles; every wait-free cycle is an accept.
  task automatic drive_cmd(input logic [31:0] word, input int ncyc,
                           output int nacc, output logic [7:0] stall_bits);
    hps_address = 4'd0;
    hps_writedata = word;
    hps_write = 1'b1;
    nacc = 0;
    stall_bits = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      stall_bits[i] = hps_waitrequest;
      if (!hps_waitrequest) begin
        nacc++;
        model_cmd(word);
      end
      @(posedge clk);
      #1;
    end
    hps_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    hps_address = addr;
    hps_read = 1'b1;
    @(negedge clk);
    data = hps_readdata;
    @(posedge clk);
    #1;
    hps_read = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    hps_address = addr;
    hps_writedata = data;
    hps_write = 1'b1;
    @(posedge clk);
    #1;
    hps_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] d;
    d = 32'h1;
    hps_address = 4'd0;
    hps_read = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      d = hps_readdata;
      @(posedge clk);
      #1;
      if (!d[0]) break;
    end
    hps_read = 1'b0;
    chk("idle_timeout", {31'd0, d[0]}, 32'd0);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    rd(4'd0, d);
    chk({tag, "_status"}, d, {30'd0, exp_err, 1'b0});
    rd(4'd1, d);
    chk({tag, "_count"}, d, exp_count);
    chk({tag, "_pxq"}, 32'(px_exp_q.size()), 32'd0);
    chk({tag, "_chq"}, 32'(ch_exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          nacc, base_cnt;
    logic [7:0]  sb;
    logic [31:0] d;

    reset_n = 1'b0;
    hps_address = '0; hps_read = 1'b0; hps_write = 1'b0; hps_writedata = '0;
    vga_px_waitrequest = 1'b0; vga_ch_waitrequest = 1'b0;
    vga_px_readdata = 16'hA5A5; vga_ch_readdata = 16'h5A5A;
    #1;
    chk("rst_strobes", {27'd0, vga_px_write, vga_ch_write, vga_px_read, vga_ch_read, hps_waitrequest}, 32'd0);
    chk("rst_px_addr", vga_px_address, 32'd0);
    chk("rst_ch_addr", vga_ch_address, 32'd0);
    chk("rst_wdata", {vga_px_writedata, vga_ch_writedata}, 32'd0);
    chk("rst_rdata", hps_readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_status("reset");

    // single SNAKE_ADD at (1,1)
    drive_cmd(mk(4'd1, 8'd0, 9'd1, 8'd1), 1, nacc, sb);
    wait_idle(20);
    chk("add_count_lit", 32'(px_wr_count), 32'd1);
    chk("add_addr_lit", last_px_addr, 32'h0800_0402);
    chk("add_data_lit", {16'd0, last_px_data}, 32'h0000_07E0);
    chk_status("add");
    rd(4'd1, d);
    chk("add_cmdcount_lit", d, 32'd1);

    // SNAKE_DEL (10,10) held for 4 cycles
    drive_cmd(mk(4'd2, 8'd0, 9'd10, 8'd10), 4, nacc, sb);
    chk("held_accepts", 32'(nacc), 32'd2);
    chk("held_stall_pattern", {24'd0, sb}, 32'h0000_0006);
    wait_idle(20);
    chk("held_wr_count", 32'(px_wr_count), 32'd3);
    chk("held_addr_lit", last_px_addr, 32'h0800_2814);
    chk("held_data_lit", {16'd0, last_px_data}, 32'd0);
    chk_status("held");

    // SNAKE_ADD at the far corner with a 3-cycle slave stall
    vga_px_waitrequest = 1'b1;
    drive_cmd(mk(4'd1, 8'd0, 9'd319, 8'd239), 1, nacc, sb);
    repeat (4) @(posedge clk);
    #1 vga_px_waitrequest = 1'b0;
    wait_idle(20);
    chk("stall_cycles", 32'(px_stall_cnt), 32'd3);
    chk("stall_wr_count", 32'(px_wr_count), 32'd4);
    chk("stall_addr_lit", last_px_addr, 32'h0803_BE7E);
    chk_status("stall");

    // FOOD_ADD, NOP and an unused code
    drive_cmd(mk(4'd3, 8'd0, 9'd100, 8'd50), 1, nacc, sb);
    wait_idle(20);
    chk("food_data_lit", {16'd0, last_px_data}, 32'h0000_F800);
    drive_cmd(mk(4'd0, 8'd0, 9'd5, 8'd5), 1, nacc, sb);
    wait_idle(20);
    drive_cmd(mk(4'd7, 8'd0, 9'd5, 8'd5), 1, nacc, sb);
    wait_idle(20);
    chk("nop_wr_count", 32'(px_wr_count), 32'd5);
    chk_status("nop");

    // out-of-range pixel commands, then software clear
    drive_cmd(mk(4'd1, 8'd0, 9'd320, 8'd5), 1, nacc, sb);
    wait_idle(20);
    rd(4'd0, d);
    chk("oor_status_lit", d, 32'h0000_0002);
    drive_cmd(mk(4'd2, 8'd0, 9'd0, 8'd240), 1, nacc, sb);
    wait_idle(20);
    chk("oor_wr_count", 32'(px_wr_count), 32'd5);
    chk_status("oor");
    wr_reg(4'd1, 32'h1);
    exp_err = 1'b0;
    exp_count = '0;
    rd(4'd0, d);
    chk("clr_status_lit", d, 32'd0);
    rd(4'd1, d);
    chk("clr_count_lit", d, 32'd0);

    // character write at the last cell, then one out of range
    drive_cmd(mk(4'd5, 8'h41, 9'd79, 8'd59), 1, nacc, sb);
    wait_idle(20);
    chk("char_count", 32'(ch_wr_count), 32'd1);
    chk("char_addr_lit", last_ch_addr, 32'h0900_1DCF);
    chk("char_data_lit", {16'd0, last_ch_data}, 32'h0000_0041);
    drive_cmd(mk(4'd5, 8'h42, 9'd80, 8'd0), 1, nacc, sb);
    wait_idle(20);
    chk("char_oor_count", 32'(ch_wr_count), 32'd1);
    chk_status("char");
    wr_reg(4'd1, 32'h1);
    exp_err = 1'b0;
    exp_count = '0;

    // full-screen clear
    base_cnt = px_wr_count;
    drive_cmd(mk(4'd4, 8'd0, 9'd0, 8'd0), 1, nacc, sb);
    wait_idle(80000);
    chk("clear_writes_lit", 32'(px_wr_count - base_cnt), 32'd76800);
    chk("clear_last_addr_lit", last_px_addr, 32'h0803_BE7E);
    chk("clear_last_data_lit", {16'd0, last_px_data}, 32'd0);
    chk_status("clear");

    // reset in the middle of a clear
    drive_cmd(mk(4'd4, 8'd0, 9'd0, 8'd0), 1, nacc, sb);
    repeat (300) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_write", {31'd0, vga_px_write}, 32'd0);
    chk("abort_addr", vga_px_address, 32'd0);
    px_exp_q.delete();
    ch_exp_q.delete();
    exp_count = '0;
    exp_err = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_write_after", {31'd0, vga_px_write}, 32'd0);
    chk_status("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
